apb_mem_responder: RTL and testbench

APB3/APB4 completer that terminates transfers in the SoC peripheral fabric: a word-addressed SRAM with byte strobes, a programmable wait-state count, and error responses. It is the responder end of the APB link, and the latency-emulation target the fabric's delay stages are calibrated against. It sits behind the APB crossbar on its own address window.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_mem_responder_if.sv | 27 ++
 rtl/apb_mem_responder_sram.sv | 35 +++
 rtl/apb_mem_responder.sv | 141 ++++++++++++++
 tb/tb_apb_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory responder: FSM state encoding,
// APB bus widths and the location of the CFG register within the address window.
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam int unsigned MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // The CFG register sits at the first word past the end of the memory.
    function automatic int unsigned cfg_offset_words(input int unsigned depth);
        return depth;
    endfunction

    localparam int unsigned CFG_OFFSET_WORDS = cfg_offset_words(MEM_DEPTH);

endpackage

// File: rtl/apb_mem_responder_if.sv
// APB3/APB4 completer-side bus bundle; the master modport drives requests, the
// slave modport returns ready, read data and error.
interface apb_mem_responder_if;
    import apb_pkg::*;

    logic [ADDR_W-1:0] in_paddr;
    logic              in_psel;
    logic              in_penable;
    logic [2:0]        in_pprot;
    logic              in_pwrite;
    logic [DATA_W-1:0] in_pwdata;
    logic [STRB_W-1:0] in_pstrb;
    logic              in_pready;
    logic [DATA_W-1:0] in_prdata;
    logic              in_pslverr;

    modport master (
        output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );

endinterface

// File: rtl/apb_mem_responder_sram.sv
// Single-port DEPTH x 32 word memory with per-byte write enables and a
// registered (synchronous) read port.
module apb_sram_array
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH
) (
    input  logic                     clock,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [STRB_W-1:0]        we,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = mem_q[addr];
    end

    // Read returns the pre-write contents when the same word is written.
    always_ff @(posedge clock) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer fronting a byte-strobed SRAM plus a wait-state CFG register;
// every transfer is stretched by the programmed number of wait states.
module apb_mem_responder
    import apb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE      = 32'h1000_0000,
    parameter int unsigned       DEPTH     = MEM_DEPTH,
    parameter logic [7:0]        WAIT_INIT = 8'd2
) (
    input  logic               clock,
    input  logic               reset,
    apb_mem_responder_if.slave apb
);

    localparam int unsigned       IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] CFG_OFF = ADDR_W'(cfg_offset_words(DEPTH)) << 2;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cfg_q, cfg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              rd_mem_q, rd_mem_d;

    logic [ADDR_W-1:0] off;
    logic              is_mem;
    logic              is_cfg;
    logic [IDX_W-1:0]  mem_idx;
    logic [STRB_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_pprot;

    assign unused_pprot = ^apb.in_pprot;

    // Decode works on the latched address so the SRAM sees a stable index for the whole wait.
    assign off     = addr_q - BASE;
    assign is_cfg  = (off == CFG_OFF);
    assign is_mem  = (off < CFG_OFF) && (off[1:0] == 2'b00);
    assign mem_idx = off[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        rd_mem_d  = rd_mem_q;
        mem_we    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (apb.in_psel && !apb.in_penable) begin
                    addr_d  = apb.in_paddr;
                    write_d = apb.in_pwrite;
                    wdata_d = apb.in_pwdata;
                    strb_d  = apb.in_pstrb;
                    cnt_d   = cfg_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!apb.in_psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d   = S_RESP;
                    pslverr_d = !is_mem && !is_cfg;
                    rd_mem_d  = is_mem && !write_q;
                    prdata_d  = (is_cfg && !write_q) ? {24'd0, cfg_q} : '0;
                    if (write_q && is_mem) begin
                        mem_we = strb_q;
                    end
                    if (write_q && is_cfg && strb_q[0]) begin
                        cfg_d = wdata_q[7:0];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset landing on the commit edge must not leave a half-done write behind.
        if (!reset) begin
            mem_we = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            cfg_q     <= WAIT_INIT;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            rd_mem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            rd_mem_q  <= rd_mem_d;
        end
    end

    apb_sram_array #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clock(clock),
        .addr (mem_idx),
        .we   (mem_we),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    assign apb.in_pready  = (state_q == S_RESP);
    assign apb.in_prdata  = (state_q == S_RESP) ? (rd_mem_q ? mem_rdata : prdata_q) : '0;
    assign apb.in_pslverr = (state_q == S_RESP) && pslverr_q;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Self-checking bench for apb_mem_responder: directed table, hand-written abort/reset
// sequences, back-to-back traffic and randomized transfers against a behavioural model.
module tb_apb_mem_responder;
    import apb_pkg::*;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          DEPTH    = MEM_DEPTH;
    localparam logic [31:0] CFGA     = BASE + 32'(4 * CFG_OFFSET_WORDS);
    localparam int          MAX_WAIT = 300;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    apb_mem_responder_if bus();

    apb_mem_responder #(
        .BASE(BASE),
        .DEPTH(DEPTH),
        .WAIT_INIT(8'd2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .apb  (bus.slave)
    );

    int nvec = 0;
    int nmis = 0;

    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];
    logic [7:0]  cfg_m;
    vec_t        vt[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: the window is a word array followed by one CFG word;
    // latency is always the wait count in force at setup plus two cycles.
    function automatic void model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] strb, output logic [31:0] exp_rdata,
                                       output logic [31:0] exp_mask, output logic exp_err, output int exp_lat);
        logic [31:0] off;
        int          w;
        off       = addr - BASE;
        exp_lat   = int'(cfg_m) + 2;
        exp_rdata = 32'h0;
        exp_mask  = 32'hFFFF_FFFF;
        exp_err   = 1'b0;
        if ((off % 4) != 0 || off > 32'(4 * DEPTH)) begin
            exp_err = 1'b1;
        end else if (off == 32'(4 * DEPTH)) begin
            if (wr) begin
                if (strb[0]) cfg_m = wdata[7:0];
            end else begin
                exp_rdata = 32'(cfg_m);
            end
        end else begin
            w = int'(off / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        mem_m[w][8*b +: 8] = wdata[8*b +: 8];
                        known_m[w][b]      = 1'b1;
                    end
                end
            end else begin
                exp_rdata = mem_m[w];
                for (int b = 0; b < 4; b++) exp_mask[8*b +: 8] = known_m[w][b] ? 8'hFF : 8'h00;
            end
        end
    endfunction

    // One full APB transfer; lat counts cycles from setup to ready (-1 on timeout).
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                                 output int lat, output logic rdy_after);
        bus.in_psel    = 1'b1;
        bus.in_penable = 1'b0;
        bus.in_paddr   = addr;
        bus.in_pwrite  = wr;
        bus.in_pwdata  = wdata;
        bus.in_pstrb   = strb;
        bus.in_pprot   = 3'($urandom);
        @(posedge clock); #1;
        lat            = 1;
        bus.in_penable = 1'b1;
        while (!bus.in_pready && lat < MAX_WAIT) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = bus.in_prdata;
        err   = bus.in_pslverr;
        if (!bus.in_pready) lat = -1;
        @(posedge clock); #1;
        rdy_after      = bus.in_pready;
        bus.in_psel    = 1'b0;
        bus.in_penable = 1'b0;
    endtask

    task automatic doCheckedXfer(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] er, em, rd;
        logic        ee, err, rdy;
        int          el, lat;
        model_xfer(wr, addr, wdata, strb, er, em, ee, el);
        applyStimulus(wr, addr, wdata, strb, rd, err, lat, rdy);
        if (ee || (!wr && em != 32'h0)) checkOutput({name, "_rdata"}, rd & em, er & em);
        checkOutput({name, "_err"}, 32'(err), 32'(ee));
        checkOutput({name, "_lat"}, 32'(lat), 32'(el));
        checkOutput({name, "_pulse"}, 32'(rdy), 32'h0);
    endtask

    task automatic addVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                          input logic chk_rd, input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.chk_rd = chk_rd; v.rdata = rdata; v.err = err; v.lat = lat;
        vt.push_back(v);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, er, em, a, d;
        logic        err, rdy, ee, seen, wr;
        logic [3:0]  s;
        int          lat, el;

        bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_paddr = '0; bus.in_pprot = '0;
        bus.in_pwrite = 1'b0; bus.in_pwdata = '0; bus.in_pstrb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = 32'h0;
            known_m[i] = 4'h0;
        end
        cfg_m = 8'd2;

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_pready", 32'(bus.in_pready), 32'h0);
        checkOutput("reset_prdata", bus.in_prdata, 32'h0);
        checkOutput("reset_pslverr", 32'(bus.in_pslverr), 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        addVec(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF,   0, 32'h0,         0, 4);
        addVec(0, BASE + 32'h10, 32'h0,         4'h0,   1, 32'hDEAD_BEEF, 0, 4);
        addVec(1, BASE + 32'h14, 32'h1122_3344, 4'hF,   0, 32'h0,         0, 4);
        addVec(1, BASE + 32'h14, 32'hAABB_CCDD, 4'b0101, 0, 32'h0,        0, 4);
        addVec(0, BASE + 32'h14, 32'h0,         4'h0,   1, 32'h11BB_33DD, 0, 4);
        addVec(0, BASE + 32'h2,  32'h0,         4'h0,   1, 32'h0,         1, 4);
        addVec(1, BASE + 32'h12, 32'hFFFF_FFFF, 4'hF,   1, 32'h0,         1, 4);
        addVec(0, CFGA + 32'h4,  32'h0,         4'h0,   1, 32'h0,         1, 4);
        addVec(1, CFGA + 32'h4,  32'h1234_5678, 4'hF,   1, 32'h0,         1, 4);
        addVec(1, BASE + 32'h10, 32'h0,         4'h0,   0, 32'h0,         0, 4);
        addVec(0, BASE + 32'h10, 32'h0,         4'h0,   1, 32'hDEAD_BEEF, 0, 4);
        addVec(0, BASE - 32'h4,  32'h0,         4'h0,   1, 32'h0,         1, 4);
        addVec(0, CFGA,          32'h0,         4'h0,   1, 32'h2,         0, 4);
        addVec(1, CFGA,          32'h0,         4'h1,   0, 32'h0,         0, 4);
        addVec(0, BASE + 32'h10, 32'h0,         4'h0,   1, 32'hDEAD_BEEF, 0, 2);
        addVec(1, CFGA,          32'h5,         4'hF,   0, 32'h0,         0, 2);
        addVec(0, CFGA,          32'h0,         4'h0,   1, 32'h5,         0, 7);
        addVec(1, CFGA,          32'hFFFF_FF09, 4'hE,   0, 32'h0,         0, 7);
        addVec(0, CFGA,          32'h0,         4'h0,   1, 32'h5,         0, 7);
        addVec(1, CFGA,          32'hABCD_EF02, 4'h1,   0, 32'h0,         0, 7);
        addVec(0, CFGA,          32'h0,         4'h0,   1, 32'h2,         0, 4);
        addVec(0, CFGA + 32'h1,  32'h0,         4'h0,   1, 32'h0,         1, 4);
        addVec(0, BASE + 32'h14, 32'h0,         4'h0,   1, 32'h11BB_33DD, 0, 4);

        foreach (vt[i]) begin
            model_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, er, em, ee, el);
            applyStimulus(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, err, lat, rdy);
            if (vt[i].chk_rd) checkOutput($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
            checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            checkOutput($sformatf("vec%0d_pulse", i), 32'(rdy), 32'h0);
        end

        // Abort: psel dropped while waiting must neither respond nor commit.
        doCheckedXfer("abort_pre", 1, BASE + 32'h20, 32'h1234_5678, 4'hF);
        bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = BASE + 32'h20;
        bus.in_pwrite = 1'b1; bus.in_pwdata = 32'hFFFF_FFFF; bus.in_pstrb = 4'hF;
        @(posedge clock); #1;
        bus.in_penable = 1'b1;
        @(posedge clock); #1;
        bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clock); #1;
            seen = seen | bus.in_pready;
        end
        checkOutput("abort_no_ready", 32'(seen), 32'h0);
        doCheckedXfer("abort_reread", 0, BASE + 32'h20, 32'h0, 4'h0);

        // Reset in the middle of a long wait.
        doCheckedXfer("rst1_cfg", 1, CFGA, 32'h5, 4'h1);
        doCheckedXfer("rst1_pre", 1, BASE + 32'h30, 32'hAAAA_5555, 4'hF);
        bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = BASE + 32'h30;
        bus.in_pwrite = 1'b1; bus.in_pwdata = 32'h0; bus.in_pstrb = 4'hF;
        @(posedge clock); #1;
        bus.in_penable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("rst1_pready", 32'(bus.in_pready), 32'h0);
        checkOutput("rst1_prdata", bus.in_prdata, 32'h0);
        checkOutput("rst1_pslverr", 32'(bus.in_pslverr), 32'h0);
        reset = 1'b1; bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        cfg_m = 8'd2;
        @(posedge clock); #1;
        doCheckedXfer("rst1_reread", 0, BASE + 32'h30, 32'h0, 4'h0);

        // Reset exactly on the edge that would commit a zero-wait write.
        doCheckedXfer("rst2_cfg", 1, CFGA, 32'h0, 4'hF);
        bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = BASE + 32'h30;
        bus.in_pwrite = 1'b1; bus.in_pwdata = 32'h0; bus.in_pstrb = 4'hF;
        @(posedge clock); #1;
        bus.in_penable = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1; bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        checkOutput("rst2_pready", 32'(bus.in_pready), 32'h0);
        cfg_m = 8'd2;
        @(posedge clock); #1;
        doCheckedXfer("rst2_reread", 0, BASE + 32'h30, 32'h0, 4'h0);

        // Back-to-back: each setup lands in the cycle after the previous ready.
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'h40 + 32'(4 * (i / 2));
            if (i % 2 == 0) doCheckedXfer($sformatf("b2b%0d", i), 1, a, $urandom, 4'hF);
            else            doCheckedXfer($sformatf("b2b%0d", i), 0, a, 32'h0, 4'h0);
        end
        @(posedge clock); #1;

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom);
            d    = $urandom;
            s    = 4'($urandom);
            if (kind <= 3) begin
                wr = 1'b1;
                a  = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            end else if (kind <= 6) begin
                wr = 1'b0;
                a  = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            end else if (kind == 7) begin
                a = CFGA;
                d = (d & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                    1:       a = CFGA + 32'(4 * $urandom_range(1, 1000));
                    default: a = BASE - 32'(4 * $urandom_range(1, 100));
                endcase
            end
            doCheckedXfer($sformatf("rand%0d", i), wr, a, d, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
